// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state codes,
// operation encoding and default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  // State enumeration, kept as plain 2-bit codes so they drop into legacy FSMs.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit/datapath (master)
// and the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             MDCtrl;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, MDCtrl, opA, opB,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, MDCtrl, opA, opB,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / restoring divide over operand magnitudes, one bit
// per cycle, with sign correction in a single FIX cycle before DONE.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic               r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_div0;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_opa_mag;
  logic [WIDTH-1:0]   w_opb_mag;
  logic               w_is_div0;
  logic [2*WIDTH-1:0] w_mult_next;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_rem_diff;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_opa_mag = bus.opA[WIDTH-1] ? -bus.opA : bus.opA;
  assign w_opb_mag = bus.opB[WIDTH-1] ? -bus.opB : bus.opB;
  assign w_is_div0 = (bus.MDCtrl == MD_DIV) && (bus.opB == '0);

  // Multiply walks the multiplier MSB-first: acc = 2*acc + (bit ? |a| : 0).
  assign w_mult_next = {r_acc[2*WIDTH-2:0], 1'b0}
                     + (r_b_mag[WIDTH-1] ? {{WIDTH{1'b0}}, r_a_mag} : '0);

  // Divide keeps quotient in the upper half and partial remainder in the lower
  // half; dividend bits are fed in from the MSB of r_a_mag.
  assign w_rem_shift = {r_acc[WIDTH-1:0], r_a_mag[WIDTH-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_b_mag};
  assign w_q_bit     = ~w_rem_diff[WIDTH];
  assign w_div_next  = {r_acc[2*WIDTH-2:WIDTH], w_q_bit,
                        w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0]};

  assign w_neg  = r_sign_a ^ r_sign_b;
  assign w_prod = w_neg ? -r_acc : r_acc;
  assign w_quot = w_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_rem  = r_sign_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= MD_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0   <= 1'b0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.MDCtrl;
            r_sign_a <= bus.opA[WIDTH-1];
            r_sign_b <= bus.opB[WIDTH-1];
            r_a_mag  <= w_opa_mag;
            r_b_mag  <= w_opb_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_div0   <= w_is_div0;
            r_state  <= w_is_div0 ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (r_op == MD_DIV) begin
            r_acc   <= w_div_next;
            r_a_mag <= r_a_mag << 1;
          end else begin
            r_acc   <= w_mult_next;
            r_b_mag <= r_b_mag << 1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_op == MD_DIV) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.div0 = (r_state == S_DONE) && r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: stimulus pushes expected results to a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic        div0;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   fails;
  int   done_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"},   {32'd0, bus.hi}, {32'd0, e.hi});
          check({e.name, "_lo"},   {32'd0, bus.lo}, {32'd0, e.lo});
          check({e.name, "_div0"}, {63'd0, bus.div0}, {63'd0, e.div0});
          $display("txn %s: hi=%08h lo=%08h div0=%0b", e.name, bus.hi, bus.lo, bus.div0);
        end
      end
    end
  end

  // Issue one op; optionally glitch start at edge glitch_edge with other operands.
  task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_div0,
                        input int exp_lat, input int glitch_edge);
    exp_t e;
    int k;
    e.name = name; e.hi = exp_hi; e.lo = exp_lo; e.div0 = exp_div0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.MDCtrl = op;
    bus.opA    = a;
    bus.opB    = b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opA   = 32'hDEADBEEF;
    bus.opB   = 32'h0BADF00D;
    bus.MDCtrl = ~op;
    check({name, "_busy_e0"}, {63'd0, bus.busy}, 64'd1);
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      if (glitch_edge > 0 && k == glitch_edge - 1) begin
        bus.start  = 1'b1;
        bus.MDCtrl = MD_DIV;
        bus.opA    = 32'd100;
        bus.opB    = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    bus.start = 1'b0;
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    @(posedge clk);
    #1;
    check({name, "_done_1cyc"}, {63'd0, bus.done}, 64'd0);
    check({name, "_busy_end"},  {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_before;
    checks = 0; fails = 0; done_seen = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.MDCtrl = MD_MULT; bus.opA = '0; bus.opB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_div0", {63'd0, bus.div0}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult_mixed", MD_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 0);
    run_op("mult_maxpos", MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33, 0);
    run_op("div_neg7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0);
    run_op("div_7_neg2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 0);
    run_op("preload", MD_DIV, 32'h275, 32'h12, 32'h11, 32'h22, 1'b0, 33, 0);
    run_op("div_by_zero", MD_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 0, 0);
    run_op("div_overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 0);
    run_op("start_in_busy", MD_MULT, 32'h1234, 32'h10, 32'h0, 32'h12340, 1'b0, 33, 5);
    run_op("accept_e35", MD_MULT, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 0);

    // Reset in the middle of a multiply: result discarded, no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.MDCtrl = MD_MULT; bus.opA = 32'd3; bus.opB = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    seen_before = done_seen;
    reset = 1'b0;
    #1;
    check("midreset_busy", {63'd0, bus.busy}, 64'd0);
    check("midreset_done", {63'd0, bus.done}, 64'd0);
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midreset_no_done", 64'(done_seen), 64'(seen_before));

    run_op("after_reset", MD_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'h1E, 1'b0, 33, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
